// File: rtl/mdu_if.sv
// Issue/result bundle between the pipeline issue logic and the MDU.
// valid/ready: an operation is taken on a rising edge where start=1, busy=0
// and MDUOp is 1-4; busy is the registered "not ready" indication and stall
// (start | busy) tells the issue logic to hold the pipeline this cycle.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDUOp, start,
        input  busy, stall, HI, LO
    );

    modport slave (
        input  A, B, MDUOp, start,
        output busy, stall, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Operands are latched on issue; the result is produced from the latched
// copies on the last busy edge, so A/B may change freely while busy.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus,
    output logic dbg_state_o
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        busy;
    logic        issue;
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, den, q_mag, r_mag;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    assign busy        = (state_q == S_BUSY);
    assign issue       = bus.start && (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);
    assign bus.busy    = busy;
    assign bus.stall   = bus.start | busy;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign dbg_state_o = state_q;

    // Result datapath: sign-magnitude division avoids the -2^31 / -1 overflow
    // trap and naturally yields quotient 0x80000000, remainder 0.
    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_neg     = signed_op & a_q[31];
        b_neg     = signed_op & b_q[31];
        a_ext     = {{32{a_neg}}, a_q};
        b_ext     = {{32{b_neg}}, b_q};
        prod      = a_ext * b_ext;
        a_mag     = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag     = b_neg ? (~b_q + 32'd1) : b_q;
        den       = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag     = a_mag / den;
        r_mag     = a_mag % den;
        res_we    = 1'b1;
        res_hi    = prod[63:32];
        res_lo    = prod[31:0];
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            res_we = (b_q != 32'd0);
            res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

    // Next-state logic: issue / mthi / mtlo when idle, countdown when busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    op_d    = bus.MDUOp;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    cnt_d   = (bus.MDUOp <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                    state_d = S_BUSY;
                end else if (bus.MDUOp == OP_MTHI) begin
                    hi_d = bus.A;
                end else if (bus.MDUOp == OP_MTLO) begin
                    lo_d = bus.A;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wins over any issue or HI/LO move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: table of directed operations with hand-computed HI/LO,
// plus hand sequences for reset, mthi/mtlo, ignored issues and abort.
module tb_mdu;
  logic clk;
  logic rst;
  logic dbg_state;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] eh;
    logic [31:0] el;
    bit          intf;
  } vec_t;

  vec_t vecs[12];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // stall must always equal start | busy
  always @(negedge clk) begin
    check("stall", {31'd0, bus.stall}, {31'd0, bus.start | bus.busy});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.start = 1'b0;
    bus.MDUOp = 3'd5; bus.A = h;
    step();
    bus.MDUOp = 3'd6; bus.A = l;
    step();
    bus.MDUOp = 3'd0;
  endtask

  // Issue one operation, scramble operands while busy, count busy cycles.
  // intf: try a mult issue and an mthi while busy; both must be ignored.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] eh,
                        input logic [31:0] el, input bit intf);
    logic [31:0] old_h, old_l;
    logic [63:0] e;
    int n;
    old_h = bus.HI;
    old_l = bus.LO;
    exp_q.push_back({eh, el});
    bus.A = a; bus.B = b; bus.MDUOp = op; bus.start = 1'b1;
    step();
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      check({name, " hold HI"}, bus.HI, old_h);
      check({name, " hold LO"}, bus.LO, old_l);
      if (intf && n == 1) begin
        bus.start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
      end else if (intf && n == 2) begin
        bus.start = 1'b0; bus.MDUOp = 3'd5; bus.A = 32'h1234;
      end else begin
        bus.start = 1'b0; bus.MDUOp = 3'd0; bus.A = $urandom; bus.B = $urandom;
      end
      step();
    end
    bus.start = 1'b0; bus.MDUOp = 3'd0;
    check({name, " busy cycles"}, 32'(n), 32'(cyc));
    e = exp_q.pop_front();
    check({name, " HI"}, bus.HI, e[63:32]);
    check({name, " LO"}, bus.LO, e[31:0]);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd4, 32'd7,        32'd0,        10, 32'h11111111, 32'h22222222, 1'b0};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[7]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[9]  = '{3'd3, 32'd100,      32'd0,        10, 32'h11111111, 32'h22222222, 1'b0};
    vecs[10] = '{3'd1, 32'h12345678, 32'd0,        5,  32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};

    rst = 1'b1;
    bus.A = '0; bus.B = '0; bus.MDUOp = 3'd0; bus.start = 1'b0;
    repeat (3) step();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset HI", bus.HI, 32'd0);
    check("reset LO", bus.LO, 32'd0);
    rst = 1'b0;
    step();

    // table-driven operations
    for (int i = 0; i < 12; i++) begin
      set_hilo(32'h11111111, 32'h22222222);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
             vecs[i].eh, vecs[i].el, vecs[i].intf);
    end

    // back-to-back: second issue on the edge right after busy falls
    run_op("b2b mult", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);
    run_op("b2b divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

    // mtlo while idle
    set_hilo(32'h55, 32'h0);
    bus.MDUOp = 3'd6; bus.A = 32'hDEADBEEF; bus.start = 1'b0;
    #1;
    check("mtlo stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.MDUOp = 3'd0;
    check("mtlo LO", bus.LO, 32'hDEADBEEF);
    check("mtlo HI", bus.HI, 32'h55);
    check("mtlo busy", {31'd0, bus.busy}, 32'd0);

    // start with non-issuing ops: no busy; mthi still applies
    bus.start = 1'b1; bus.MDUOp = 3'd0;
    step();
    check("start op0 busy", {31'd0, bus.busy}, 32'd0);
    bus.MDUOp = 3'd7;
    step();
    check("start op7 busy", {31'd0, bus.busy}, 32'd0);
    bus.MDUOp = 3'd5; bus.A = 32'h77;
    step();
    bus.start = 1'b0; bus.MDUOp = 3'd0;
    check("start mthi busy", {31'd0, bus.busy}, 32'd0);
    check("start mthi HI", bus.HI, 32'h77);
    check("start mthi LO", bus.LO, 32'hDEADBEEF);

    // reset beats mthi on the same edge
    bus.MDUOp = 3'd5; bus.A = 32'hFFFF; rst = 1'b1;
    step();
    rst = 1'b0; bus.MDUOp = 3'd0;
    check("rst vs mthi HI", bus.HI, 32'd0);

    // reset during the 3rd busy cycle of a mult aborts it
    set_hilo(32'hAAAA, 32'hBBBB);
    bus.A = 32'd5; bus.B = 32'd6; bus.MDUOp = 3'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.MDUOp = 3'd0;
    check("abort busy c1", {31'd0, bus.busy}, 32'd1);
    step();
    step();
    check("abort busy c3", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort HI", bus.HI, 32'd0);
    check("abort LO", bus.LO, 32'd0);
    repeat (8) step();
    check("abort late busy", {31'd0, bus.busy}, 32'd0);
    check("abort late HI", bus.HI, 32'd0);
    check("abort late LO", bus.LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (>=1).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (>=1).
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port A  input  32  operand from GRF RD1 (rs value).
REQ-006 Port B  input  32  operand from GRF RD2 (rt value).
REQ-007 Port MDUOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 Port start  input  1  qualifies MDUOp 1-4 as an issue in this cycle.
REQ-009 Port busy  output  1  registered; high while an operation is in flight.
REQ-010 Port stall  output  1  combinational: start | busy, a hint for the issue logic.
REQ-011 Port HI  output  32  registered HI register; feeds the GRF write-data mux for mfhi.
REQ-012 Port LO  output  32  registered LO register; feeds the GRF write-data mux for mflo.

Function
REQ-013 The block SHALL accept an issue at an edge where start=1, busy=0 and MDUOp is 1-4; it latches A, B and MDUOp, loads a down-counter with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4), and sets busy=1.
REQ-014 The block SHALL ignore start while busy=1; latched operands, counter and HI/LO are unaffected.
REQ-015 The block SHALL ignore start=1 with MDUOp 0, 5, 6 or 7; no busy period follows.
REQ-016 At each edge while busy=1 the counter SHALL decrement; at the edge where it equals 1, HI/LO are written with the result and busy returns to 0.
REQ-017 busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles after the issue edge, and HI/LO SHALL hold their old values for that whole period.
REQ-018 mult SHALL form a signed 64-bit product {HI,LO}; multu SHALL form an unsigned 64-bit product.
REQ-019 div SHALL set LO to the signed quotient truncated toward zero and HI to the remainder, which takes the sign of the dividend; divu does the same unsigned.
REQ-020 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 div or divu with B=0 SHALL complete with normal busy timing and leave HI and LO unchanged.
REQ-022 mthi (5) or mtlo (6) with busy=0 SHALL write A into HI or LO at the next edge, whether or not start is asserted; the other register keeps its value.
REQ-023 mthi or mtlo with busy=1 SHALL be ignored.
REQ-024 Back-to-back operation: an issue SHALL be accepted at the edge immediately after the cycle in which busy falls.
REQ-025 Results SHALL be computed from the operands latched at the issue edge; changes on A and B during busy have no effect.

Reset
REQ-026 At an edge with rst=1, HI=0, LO=0, busy=0 and counter=0 SHALL be set; this overrides any issue or mthi/mtlo on the same edge.
REQ-027 rst asserted mid-operation SHALL abort the operation; no result is written after reset.

Verification
REQ-028 mult with A=0xFFFFFFFE (-2) and B=3 issued at edge 0 -> busy=1 for edges 1-5; at edge 5 busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 multu with A=0xFFFFFFFF and B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div with A=-7 and B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu with A=7 and B=0 -> HI/LO unchanged after 10 cycles.
REQ-031 A second start of mult while div is busy, plus mthi with A=0x1234, both during busy -> both ignored; final values come from the div only.
REQ-032 mtlo with A=0xDEADBEEF while idle -> LO=0xDEADBEEF next cycle, HI unchanged, busy stays 0, stall=0.
REQ-033 rst at the 3rd busy cycle of mult -> busy=0, HI=LO=0 next cycle, no later write; stall equals start|busy in every cycle.
